keypad_emulator: RTL

- Synthesizable model of a 4x4 matrix keypad: the responder end of the column-scan / row-sense interface.
- Takes key codes over a valid/ready handshake and drives `fil` in response to the scanner's `col` drive.
- Emulates contact bounce, hold time measured in scan sweeps, and a release gap.
- Sits beside `module_top` in on-board self-test and loopback builds, where it replaces the physical keypad.

---
 rtl/keypad_pkg.sv | 73 +++++++
 rtl/keypad_emulator_sat_counter.sv | 38 +++
 rtl/keypad_emulator.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the 4x4 keypad emulator.
//   - key_code encodings (digits, A-D, '*', '#')
//   - FSM state type
//   - key_decode(): key_code -> {row, col} position in the matrix,
//     usable by the scanner decode and by benches
//   - row_onehot(): row index -> active-high row sense pattern
//   - cnt_width(): counter width able to hold 0..limit
package keypad_pkg;

    localparam logic [3:0] KEY_0    = 4'h0;
    localparam logic [3:0] KEY_1    = 4'h1;
    localparam logic [3:0] KEY_2    = 4'h2;
    localparam logic [3:0] KEY_3    = 4'h3;
    localparam logic [3:0] KEY_4    = 4'h4;
    localparam logic [3:0] KEY_5    = 4'h5;
    localparam logic [3:0] KEY_6    = 4'h6;
    localparam logic [3:0] KEY_7    = 4'h7;
    localparam logic [3:0] KEY_8    = 4'h8;
    localparam logic [3:0] KEY_9    = 4'h9;
    localparam logic [3:0] KEY_A    = 4'hA;
    localparam logic [3:0] KEY_B    = 4'hB;
    localparam logic [3:0] KEY_C    = 4'hC;
    localparam logic [3:0] KEY_D    = 4'hD;
    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BOUNCE = 2'd1,
        ST_PRESS  = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } key_pos_t;

    // Layout:  row0 = 1 2 3 A | row1 = 4 5 6 B | row2 = 7 8 9 C | row3 = * 0 # D
    function automatic key_pos_t key_decode(input logic [3:0] code);
        key_pos_t p;
        p = {2'd0, 2'd0};
        case (code)
            KEY_1:    p = {2'd0, 2'd0};
            KEY_2:    p = {2'd0, 2'd1};
            KEY_3:    p = {2'd0, 2'd2};
            KEY_A:    p = {2'd0, 2'd3};
            KEY_4:    p = {2'd1, 2'd0};
            KEY_5:    p = {2'd1, 2'd1};
            KEY_6:    p = {2'd1, 2'd2};
            KEY_B:    p = {2'd1, 2'd3};
            KEY_7:    p = {2'd2, 2'd0};
            KEY_8:    p = {2'd2, 2'd1};
            KEY_9:    p = {2'd2, 2'd2};
            KEY_C:    p = {2'd2, 2'd3};
            KEY_STAR: p = {2'd3, 2'd0};
            KEY_0:    p = {2'd3, 2'd1};
            KEY_HASH: p = {2'd3, 2'd2};
            KEY_D:    p = {2'd3, 2'd3};
            default:  p = {2'd0, 2'd0};
        endcase
        return p;
    endfunction

    function automatic logic [3:0] row_onehot(input logic [1:0] row);
        return 4'b0001 << row;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit == 0) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/keypad_emulator_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
//   clk    in  : system clock
//   rst_in in  : synchronous active-high reset (count -> 0)
//   clr    in  : synchronous clear (priority over en)
//   en     in  : count one step
//   term   out : high when the enabled step reaches (or is already at) LIMIT
// The count stops at LIMIT and never wraps.
module sat_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned LIMIT = 15
) (
    input  logic clk,
    input  logic rst_in,
    input  logic clr,
    input  logic en,
    output logic term
);

    localparam logic [WIDTH:0] LIM = (WIDTH + 1)'(LIMIT);

    logic [WIDTH-1:0] count;
    logic [WIDTH:0]   count_inc;

    assign count_inc = {1'b0, count} + (WIDTH + 1)'(1);

    // Flag is looked at together with en so the step that completes the
    // count is the one that triggers the owner's state change.
    assign term = en && (count_inc >= LIM);

    always_ff @(posedge clk) begin
        if (rst_in || clr) begin
            count <= '0;
        end else if (en && ({1'b0, count} < LIM)) begin
            count <= count_inc[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: responder end of a 4x4 column-scan / row-sense keypad.
// Accepts a key code over valid/ready, then answers the scanner's column
// drive on the row lines with contact bounce, a hold of HOLD_SCANS full
// sweeps, and a release gap before signalling done.
//   clk       in  : system clock
//   rst_in    in  : synchronous active-high reset
//   col[3:0]  in  : column drive from scanner, active-high
//   key_code  in  : key to press (0-9, A-D, E='*', F='#')
//   key_valid in  : request present
//   key_ready out : high only in IDLE
//   fil[3:0]  out : row sense, registered, active-high
//   busy      out : high outside IDLE
//   done      out : one-cycle pulse after the release gap
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int unsigned HOLD_SCANS    = 4,
    parameter int unsigned BOUNCE_CYCLES = 8,
    parameter int unsigned GAP_CYCLES    = 16
) (
    input  logic       clk,
    input  logic       rst_in,
    input  logic [3:0] col,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    output logic       key_ready,
    output logic [3:0] fil,
    output logic       busy,
    output logic       done
);

    localparam int unsigned BW = cnt_width(BOUNCE_CYCLES);
    localparam int unsigned HW = cnt_width(HOLD_SCANS);
    localparam int unsigned GW = cnt_width(GAP_CYCLES);

    state_t     state, state_next;
    logic [3:0] fil_next;
    logic       done_next;
    logic       load;

    logic [1:0] row_q, col_q;
    logic       toggle;
    logic       col0_q;
    key_pos_t   pos;

    logic       hit, rise;
    logic       b_clr, b_en, b_term;
    logic       s_clr, s_en, s_term;
    logic       g_clr, g_en, g_term;

    assign pos       = key_decode(key_code);
    assign hit       = col[col_q];
    assign rise      = col[0] & ~col0_q;
    assign key_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    sat_counter #(.WIDTH(BW), .LIMIT(BOUNCE_CYCLES)) u_bounce_cnt (
        .clk    (clk),
        .rst_in (rst_in),
        .clr    (b_clr),
        .en     (b_en),
        .term   (b_term)
    );

    sat_counter #(.WIDTH(HW), .LIMIT(HOLD_SCANS)) u_sweep_cnt (
        .clk    (clk),
        .rst_in (rst_in),
        .clr    (s_clr),
        .en     (s_en),
        .term   (s_term)
    );

    sat_counter #(.WIDTH(GW), .LIMIT(GAP_CYCLES)) u_gap_cnt (
        .clk    (clk),
        .rst_in (rst_in),
        .clr    (g_clr),
        .en     (g_en),
        .term   (g_term)
    );

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            fil    <= '0;
            done   <= 1'b0;
            row_q  <= '0;
            col_q  <= '0;
            toggle <= 1'b1;
            col0_q <= 1'b0;
        end else begin
            fil    <= fil_next;
            done   <= done_next;
            col0_q <= col[0];
            // Re-armed to 1 outside BOUNCE so each bounce phase opens closed.
            toggle <= (state == ST_BOUNCE) ? ~toggle : 1'b1;
            if (load) begin
                row_q <= pos.row;
                col_q <= pos.col;
            end
        end
    end

    // Each counter is held clear outside its own state, so entry always
    // starts from zero.
    always_comb begin
        state_next = state;
        fil_next   = '0;
        done_next  = 1'b0;
        load       = 1'b0;
        b_clr      = 1'b1;
        b_en       = 1'b0;
        s_clr      = 1'b1;
        s_en       = 1'b0;
        g_clr      = 1'b1;
        g_en       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (key_valid) begin
                    load       = 1'b1;
                    state_next = (BOUNCE_CYCLES == 0) ? ST_PRESS : ST_BOUNCE;
                end
            end
            ST_BOUNCE: begin
                b_clr = 1'b0;
                b_en  = 1'b1;
                if (hit && toggle) begin
                    fil_next = row_onehot(row_q);
                end
                if (b_term) begin
                    state_next = ST_PRESS;
                end
            end
            ST_PRESS: begin
                s_clr = 1'b0;
                s_en  = rise;
                if (hit) begin
                    fil_next = row_onehot(row_q);
                end
                if (s_term) begin
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                g_clr = 1'b0;
                g_en  = 1'b1;
                if (g_term) begin
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule
